// File: rtl/inst_sram_responder.sv
// Instruction SRAM-like responder: queues fetch requests, reads a 1-cycle RAM,
// answers strictly in order. Ports: inst_* handshake to master, ram_* to RAM.
module inst_sram_responder #(
  parameter int DEPTH = 4,
  parameter int LAT   = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        ram_en,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_rdata
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [2:0]    WINIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
  localparam bit            HAS_WAIT = (LAT > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ
  } state_t;

  state_t        state;
  logic [29:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          resp_pend;
  logic [2:0]    wait_cnt;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;
  logic          unused_ok;

  assign unused_ok = ^inst_addr[1:0];

  // A response in flight still holds its slot until data_ok.
  assign occ = {1'b0, fifo_cnt} + {{CW{1'b0}}, resp_pend};
  assign inst_addr_ok = occ < CW1'(DEPTH);
  assign push = inst_req && inst_addr_ok;
  assign pop  = (state == S_READ);

  assign ram_en       = pop;
  assign ram_addr     = pop ? {mem[rd_ptr], 2'b00} : 32'h0;
  assign inst_data_ok = resp_pend;
  assign inst_rdata   = resp_pend ? ram_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= inst_addr[31:2];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      resp_pend <= 1'b0;
      wait_cnt  <= 3'd0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)
        fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push)
        fifo_cnt <= fifo_cnt - CW'(1);
      resp_pend <= pop;
      unique case (state)
        S_IDLE: begin
          if (fifo_cnt != '0) begin
            if (HAS_WAIT) begin
              state    <= S_WAIT;
              wait_cnt <= WINIT;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) state <= S_READ;
          else wait_cnt <= wait_cnt - 3'd1;
        end
        S_READ: begin
          // Same-cycle push is not visible yet; only older entries count.
          if (fifo_cnt > CW'(1)) begin
            if (HAS_WAIT) begin
              state    <= S_WAIT;
              wait_cnt <= WINIT;
            end else begin
              state <= S_READ;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: two instances (D4/L0, D2/L3), in-order
// scoreboard per instance, directed timing cases plus random traffic.
module tb_inst_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req      [2];
  logic [31:0] addr     [2];
  logic        addr_ok  [2];
  logic        data_ok  [2];
  logic [31:0] rdata    [2];
  logic        ram_en   [2];
  logic [31:0] ram_addr [2];
  logic [31:0] ram_rdata[2];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f(logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h3BC0_0001;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int D = (g == 0) ? 4 : 2;
    localparam int L = (g == 0) ? 0 : 3;
    logic [31:0] q[$];
    logic [31:0] aq[$];
    int outst = 0;

    inst_sram_responder #(.DEPTH(D), .LAT(L)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .inst_req    (req[g]),
      .inst_addr   (addr[g]),
      .inst_addr_ok(addr_ok[g]),
      .inst_data_ok(data_ok[g]),
      .inst_rdata  (rdata[g]),
      .ram_en      (ram_en[g]),
      .ram_addr    (ram_addr[g]),
      .ram_rdata   (ram_rdata[g])
    );

    // RAM model: 1-cycle read, garbage when not reading.
    always @(posedge clk)
      ram_rdata[g] <= ram_en[g] ? f(ram_addr[g]) : $urandom;

    always @(negedge clk) begin
      if (!resetn) begin
        q.delete();
        aq.delete();
        outst = 0;
      end else begin
        chk($sformatf("addr_ok%0d", g), {31'b0, addr_ok[g]},
            {31'b0, outst < D});
        if (data_ok[g]) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL dok%0d: got data_ok=1 want none queued", g);
          end else if (rdata[g] !== q[0]) begin
            bad++;
            $display("FAIL rdata%0d: got %h want %h", g, rdata[g], q[0]);
          end
          if (q.size() != 0) void'(q.pop_front());
          outst--;
        end else begin
          chk($sformatf("rdata_idle%0d", g), rdata[g], 32'h0);
        end
        if (ram_en[g]) begin
          total++;
          if (aq.size() == 0) begin
            bad++;
            $display("FAIL ram_en%0d: got ram_en=1 want none queued", g);
          end else begin
            if (ram_addr[g] !== aq[0]) begin
              bad++;
              $display("FAIL ram_addr%0d: got %h want %h",
                       g, ram_addr[g], aq[0]);
            end
            void'(aq.pop_front());
          end
        end
        if (req[g] && addr_ok[g]) begin
          q.push_back(f(addr[g]));
          aq.push_back(addr[g] & 32'hFFFF_FFFC);
          outst++;
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(int i, logic [31:0] a, output int acc);
    int n;
    bit ok;
    req[i] = 1'b1;
    addr[i] = a;
    n = 0;
    ok = 0;
    acc = -1;
    while (n < 200 && !ok) begin
      @(negedge clk);
      if (addr_ok[i]) begin
        ok = 1;
        acc = cyc;
      end
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout%0d: got none want accept", i);
    end
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  // sel 0: ram_en, sel 1: data_ok. Returns cycle seen or -1.
  task automatic wait_on(int i, int sel, output int c);
    int n;
    n = 0;
    c = -1;
    while (n < 100 && c < 0) begin
      @(negedge clk);
      if ((sel == 0) ? ram_en[i] : data_ok[i]) c = cyc;
      n++;
    end
    if (c < 0) begin
      total++;
      bad++;
      $display("FAIL wait_timeout%0d_%0d: got none want event", i, sel);
    end
  endtask

  task automatic rand_drive(int i);
    int acc;
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(i, $urandom, acc);
    end
  endtask

  initial begin
    int acc, acc0, c, cnt, nacc;
    int d[5];
    bit acc_now;
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      addr[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_addr_ok", {31'b0, addr_ok[i]}, 32'h1);
      chk("rst_data_ok", {31'b0, data_ok[i]}, 32'h0);
      chk("rst_rdata", rdata[i], 32'h0);
      chk("rst_ram_en", {31'b0, ram_en[i]}, 32'h0);
      chk("rst_ram_addr", ram_addr[i], 32'h0);
    end

    // Single request, LAT=0.
    @(posedge clk);
    #1;
    issue(0, 32'h1FC0_0000, acc);
    wait_on(0, 0, c);
    chk("t1_ren_cyc", c, acc + 2);
    chk("t1_ram_addr", ram_addr[0], 32'h1FC0_0000);
    wait_on(0, 1, c);
    chk("t1_dok_cyc", c, acc + 3);
    chk("t1_rdata", rdata[0], 32'h2400_0001);

    // Six back-to-back, LAT=0.
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          issue(0, 32'h100 + 32'(4 * k), acc);
          if (k == 0) acc0 = acc;
        end
      end
      begin
        wait_on(0, 1, c);
        repeat (5) begin
          @(negedge clk);
          chk("t2_dok_run", {31'b0, data_ok[0]}, 32'h1);
        end
      end
    join
    chk("t2_no_stall", acc - acc0, 5);
    chk("t2_first_dok", c, acc0 + 3);

    // Unaligned address.
    @(posedge clk);
    #1;
    issue(0, 32'h1002, acc);
    wait_on(0, 0, c);
    chk("t4_ram_addr", ram_addr[0], 32'h1000);
    wait_on(0, 1, c);
    chk("t4_rdata", rdata[0], f(32'h1000));

    // LAT=3, DEPTH=2, five held requests.
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          issue(1, 32'h400 + 32'(4 * k), acc);
          if (k == 0) acc0 = acc;
        end
      end
      begin
        for (int k = 0; k < 5; k++) wait_on(1, 1, d[k]);
      end
    join
    chk("t3_first_dok", d[0], acc0 + 6);
    for (int k = 1; k < 5; k++) chk("t3_spacing", d[k] - d[k-1], 4);

    // Random traffic on both instances.
    @(posedge clk);
    #1;
    fork
      rand_drive(0);
      rand_drive(1);
    join
    repeat (40) @(negedge clk);
    chk("drain0", ch[0].q.size(), 0);
    chk("drain1", ch[1].q.size(), 0);

    // Reset with traffic queued and a read in flight.
    @(posedge clk);
    #1;
    addr[0] = 32'h2000;
    req[0] = 1'b1;
    nacc = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc_now = addr_ok[0];
      if (ram_en[0] && nacc >= 3) break;
      @(posedge clk);
      #1;
      if (acc_now) begin
        nacc++;
        addr[0] = addr[0] + 32'h4;
      end
    end
    chk("r_inflight", {31'b0, ram_en[0]}, 32'h1);
    #1;
    resetn = 1'b0;
    req[0] = 1'b0;
    #1;
    chk("r_addr_ok", {31'b0, addr_ok[0]}, 32'h1);
    chk("r_ram_en", {31'b0, ram_en[0]}, 32'h0);
    chk("r_data_ok", {31'b0, data_ok[0]}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_ok[0]) cnt++;
    end
    chk("r_no_dok", cnt, 0);
    @(posedge clk);
    #1;
    issue(0, 32'h3000, acc);
    wait_on(0, 1, c);
    chk("r_next_dok", c, acc + 3);
    chk("r_next_rdata", rdata[0], f(32'h3000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_sram_responder.md
# inst_sram_responder

Instruction-side SRAM-like slave: the responder end of the `inst_req/inst_addr_ok/inst_data_ok/inst_rdata` handshake used by the fetch stages. It accepts up to DEPTH outstanding read requests and reads a 1-cycle-latency synchronous instruction RAM. It returns data strictly in request order, with an optional programmable wait-state count for latency stress.

## Interface
- DEPTH, 4: maximum accepted-but-unanswered requests (2..8).
- LAT, 0: extra wait cycles inserted before each RAM read (0..7).
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  master request valid (read only).
- inst_addr  in  32  byte address; bits [1:0] ignored.
- inst_addr_ok  out  1  request accepted this cycle when high together with inst_req.
- inst_data_ok  out  1  one-cycle pulse per response, in acceptance order; master cannot back-pressure.
- inst_rdata  out  32  response word, valid only with inst_data_ok.
- ram_en  out  1  RAM read strobe.
- ram_addr  out  32  word-aligned RAM address, {addr[31:2],2'b00}.
- ram_rdata  in  32  RAM data, valid the cycle after ram_en.

## Operation
- Address FIFO: DEPTH entries × 30 bits, with wr_ptr and rd_ptr of log2(DEPTH) bits that wrap modulo DEPTH, plus fifo_cnt.
- Accept = inst_req && inst_addr_ok. On accept, push inst_addr[31:2].
- `resp_pend` is a register set in the cycle after a READ.
- Occupancy = fifo_cnt + resp_pend.
- inst_addr_ok = (occupancy < DEPTH), combinational. It is independent of inst_req.
- FSM states:
  - IDLE: if fifo_cnt != 0, go to WAIT when LAT > 0 (load wait_cnt = LAT-1), or to READ when LAT = 0.
  - WAIT: decrement wait_cnt; go to READ when it reaches 0.
  - READ: ram_en = 1 and ram_addr = head. Pop the FIFO and set resp_pend. Next state: if the FIFO is still non-empty, WAIT (LAT > 0) or READ (LAT = 0); otherwise IDLE.
- Response cycle (resp_pend = 1): inst_data_ok = 1 and inst_rdata = ram_rdata. resp_pend clears unless the same cycle is also a READ.
- inst_rdata = inst_data_ok ? ram_rdata : 32'h0.
- There is no cancel input. Every accepted request is answered, including across a pipeline flush. The master discards stale data itself.
- A push and a pop in the same cycle leave fifo_cnt unchanged. Both pointers advance.
- Push and pop never touch the same slot while fifo_cnt is 0, because a pop requires fifo_cnt != 0 at the cycle start. A request pushed in cycle T is first visible to the FSM in T+1.

## Timing
- Reset (resetn low, asynchronous): FSM = IDLE, all pointers and counts 0, resp_pend = 0.
  - inst_data_ok = 0, inst_rdata = 0, ram_en = 0, ram_addr = 0.
  - inst_addr_ok = 1.
- Reset asserted mid-operation drops all queued and in-flight requests. No data_ok is produced for them.
- Single request accepted at edge of cycle T from idle:
  - LAT = 0: READ in T+1, data_ok in T+2.
  - LAT = L: WAIT in T+1..T+L, READ in T+L+1, data_ok in T+L+2.
- Throughput:
  - LAT = 0: one response per cycle (READ overlaps the previous response).
  - LAT = L: one response per L+1 cycles.
- Full: occupancy = DEPTH forces inst_addr_ok low. It rises in the cycle after the response that frees a slot, so a pop and an accept never race on a full FIFO.
- A request held through inst_addr_ok low is accepted in the first cycle inst_addr_ok is high. inst_addr may change only after acceptance.

## Test plan
- LAT=0, DEPTH=4, one request addr 0x1FC0_0000, RAM word 0x2400_0001 -> ram_en in T+1 with ram_addr 0x1FC0_0000; data_ok in T+2 with rdata 0x2400_0001; rdata 0 in all other cycles.
- LAT=0, six back-to-back requests addr 0x100,0x104,…,0x114 held continuously -> all accepted with no addr_ok drop; data_ok high six consecutive cycles starting T+2; data returned in order.
- LAT=3, DEPTH=2, five requests held continuously -> addr_ok low whenever occupancy = 2; responses spaced exactly 4 cycles apart; first data_ok at T+5; order preserved.
- Unaligned addr 0x1002 -> ram_addr 0x1000; data returned normally.
- Simultaneous accept and pop at fifo_cnt=DEPTH-1 -> fifo_cnt unchanged; pointers wrap from DEPTH-1 to 0; no lost or duplicated address.
- resetn pulsed low with 3 requests queued and one read in flight -> no data_ok after reset; addr_ok=1 and ram_en=0 immediately; next request after reset answered at T+2 (LAT=0).
